// File: rtl/pb_field_decoder.sv
// rtl/pb_field_decoder.sv - streaming protobuf wire-format field decoder
// Walks key/value pairs, emits one record per field and forwards length-delimited payload bytes.
module pb_field_decoder #(
  parameter int MAX_VARINT_BYTES = 10,
  parameter int LEN_W            = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [28:0] out_field_num,
  output logic [2:0]  out_wire_type,
  output logic [63:0] out_value,
  output logic        pld_valid,
  input  logic        pld_ready,
  output logic [7:0]  pld_data,
  output logic        pld_last,
  output logic        err,
  output logic [1:0]  err_code,
  output logic        msg_end
);

  localparam int CNT_W = ($clog2(MAX_VARINT_BYTES) > 3) ? $clog2(MAX_VARINT_BYTES) : 3;

  localparam logic [1:0] ERR_OVF   = 2'd0;
  localparam logic [1:0] ERR_WT    = 2'd1;
  localparam logic [1:0] ERR_TRUNC = 2'd2;
  localparam logic [1:0] ERR_FN0   = 2'd3;

  typedef enum logic [2:0] {
    S_KEY,
    S_VARINT,
    S_FIX,
    S_LEN,
    S_EMIT,
    S_PAYLOAD,
    S_DRAIN
  } state_e;

  state_e             state_q, state_d;
  logic [63:0]        acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         wt_q, wt_d;
  logic [28:0]        fnum_q, fnum_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic               last_q, last_d;
  logic               out_valid_q, out_valid_d;
  logic [28:0]        out_field_num_q, out_field_num_d;
  logic [2:0]         out_wire_type_q, out_wire_type_d;
  logic [63:0]        out_value_q, out_value_d;
  logic               err_q, err_d;
  logic [1:0]         err_code_q, err_code_d;
  logic               msg_end_q, msg_end_d;

  logic               accept;
  logic [6:0]         vshift;
  logic [5:0]         fshift;
  logic [63:0]        varint_acc;
  logic [63:0]        fix_acc;
  logic               cnt_max;
  logic               fix_done;
  logic               len_too_big;
  logic [2:0]         key_wt;
  logic               do_emit;
  logic [63:0]        emit_value;
  logic               raise;
  logic [1:0]         raise_code;

  assign out_valid     = out_valid_q;
  assign out_field_num = out_field_num_q;
  assign out_wire_type = out_wire_type_q;
  assign out_value     = out_value_q;
  assign err           = err_q;
  assign err_code      = err_code_q;
  assign msg_end       = msg_end_q;
  assign pld_data      = in_data;

  always_comb begin
    in_ready  = 1'b1;
    pld_valid = 1'b0;
    pld_last  = 1'b0;
    case (state_q)
      S_EMIT: in_ready = 1'b0;
      S_PAYLOAD: begin
        in_ready  = pld_ready;
        pld_valid = in_valid;
        // A truncated payload is still closed off so consumers see a field boundary.
        pld_last  = (rem_q == LEN_W'(1)) || in_last;
      end
      default: in_ready = 1'b1;
    endcase
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    vshift      = 7'(cnt_q) * 7'd7;
    fshift      = {cnt_q[2:0], 3'b000};
    varint_acc  = acc_q | (64'(in_data[6:0]) << vshift);
    fix_acc     = acc_q | (64'(in_data) << fshift);
    cnt_max     = (cnt_q == CNT_W'(MAX_VARINT_BYTES - 1));
    fix_done    = (cnt_q[2:0] == ((wt_q == 3'd1) ? 3'd7 : 3'd3));
    len_too_big = ((varint_acc >> LEN_W) != 64'd0);
    key_wt      = varint_acc[2:0];
  end

  always_comb begin
    state_d         = state_q;
    acc_d           = acc_q;
    cnt_d           = cnt_q;
    wt_d            = wt_q;
    fnum_d          = fnum_q;
    rem_d           = rem_q;
    last_d          = last_q;
    out_valid_d     = out_valid_q;
    out_field_num_d = out_field_num_q;
    out_wire_type_d = out_wire_type_q;
    out_value_d     = out_value_q;
    err_d           = 1'b0;
    err_code_d      = err_code_q;
    msg_end_d       = 1'b0;
    do_emit         = 1'b0;
    emit_value      = 64'd0;
    raise           = 1'b0;
    raise_code      = ERR_OVF;

    case (state_q)
      S_KEY: begin
        if (accept) begin
          acc_d = varint_acc;
          cnt_d = cnt_q + CNT_W'(1);
          if (in_data[7]) begin
            if (cnt_max) begin
              raise      = 1'b1;
              raise_code = ERR_OVF;
            end else if (in_last) begin
              raise      = 1'b1;
              raise_code = ERR_TRUNC;
            end
          end else begin
            acc_d  = 64'd0;
            cnt_d  = '0;
            wt_d   = key_wt;
            fnum_d = varint_acc[31:3];
            if (!(key_wt == 3'd0 || key_wt == 3'd1 || key_wt == 3'd2 || key_wt == 3'd5)) begin
              raise      = 1'b1;
              raise_code = ERR_WT;
            end else if (varint_acc[63:3] == 61'd0) begin
              raise      = 1'b1;
              raise_code = ERR_FN0;
            end else if (in_last) begin
              raise      = 1'b1;
              raise_code = ERR_TRUNC;
            end else begin
              case (key_wt)
                3'd0:    state_d = S_VARINT;
                3'd2:    state_d = S_LEN;
                default: state_d = S_FIX;
              endcase
            end
          end
        end
      end

      S_VARINT, S_LEN: begin
        if (accept) begin
          acc_d = varint_acc;
          cnt_d = cnt_q + CNT_W'(1);
          if (in_data[7]) begin
            if (cnt_max) begin
              raise      = 1'b1;
              raise_code = ERR_OVF;
            end else if (in_last) begin
              raise      = 1'b1;
              raise_code = ERR_TRUNC;
            end
          end else if (state_q == S_VARINT) begin
            do_emit    = 1'b1;
            emit_value = varint_acc;
            last_d     = in_last;
          end else if (len_too_big) begin
            raise      = 1'b1;
            raise_code = ERR_OVF;
          end else if (in_last && (varint_acc != 64'd0)) begin
            raise      = 1'b1;
            raise_code = ERR_TRUNC;
          end else begin
            do_emit    = 1'b1;
            emit_value = varint_acc;
            rem_d      = varint_acc[LEN_W-1:0];
            last_d     = in_last;
          end
        end
      end

      S_FIX: begin
        if (accept) begin
          acc_d = fix_acc;
          cnt_d = cnt_q + CNT_W'(1);
          if (fix_done) begin
            do_emit    = 1'b1;
            emit_value = fix_acc;
            last_d     = in_last;
          end else if (in_last) begin
            raise      = 1'b1;
            raise_code = ERR_TRUNC;
          end
        end
      end

      S_EMIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          msg_end_d   = last_q;
          last_d      = 1'b0;
          state_d     = (wt_q == 3'd2 && rem_q != '0) ? S_PAYLOAD : S_KEY;
        end
      end

      S_PAYLOAD: begin
        if (accept) begin
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d   = S_KEY;
            msg_end_d = in_last;
          end else if (in_last) begin
            raise      = 1'b1;
            raise_code = ERR_TRUNC;
          end
        end
      end

      S_DRAIN: begin
        if (accept && in_last) state_d = S_KEY;
      end

      default: state_d = S_KEY;
    endcase

    if (do_emit) begin
      out_valid_d     = 1'b1;
      out_field_num_d = fnum_q;
      out_wire_type_d = wt_q;
      out_value_d     = emit_value;
      state_d         = S_EMIT;
      acc_d           = 64'd0;
      cnt_d           = '0;
    end

    // Truncation or an error on the message's last byte leaves nothing to drain.
    if (raise) begin
      err_d      = 1'b1;
      err_code_d = raise_code;
      acc_d      = 64'd0;
      cnt_d      = '0;
      state_d    = (in_last || raise_code == ERR_TRUNC) ? S_KEY : S_DRAIN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_KEY;
      acc_q           <= 64'd0;
      cnt_q           <= '0;
      wt_q            <= 3'd0;
      fnum_q          <= 29'd0;
      rem_q           <= '0;
      last_q          <= 1'b0;
      out_valid_q     <= 1'b0;
      out_field_num_q <= 29'd0;
      out_wire_type_q <= 3'd0;
      out_value_q     <= 64'd0;
      err_q           <= 1'b0;
      err_code_q      <= 2'd0;
      msg_end_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      acc_q           <= acc_d;
      cnt_q           <= cnt_d;
      wt_q            <= wt_d;
      fnum_q          <= fnum_d;
      rem_q           <= rem_d;
      last_q          <= last_d;
      out_valid_q     <= out_valid_d;
      out_field_num_q <= out_field_num_d;
      out_wire_type_q <= out_wire_type_d;
      out_value_q     <= out_value_d;
      err_q           <= err_d;
      err_code_q      <= err_code_d;
      msg_end_q       <= msg_end_d;
    end
  end

endmodule

// File: tb/tb_pb_field_decoder.sv
// tb/tb_pb_field_decoder.sv - scoreboard bench for pb_field_decoder
// Expected records, payload bytes and error codes are queued at stimulus time and popped by a monitor.
module tb_pb_field_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [28:0] out_field_num;
  logic [2:0]  out_wire_type;
  logic [63:0] out_value;
  logic        pld_valid;
  logic        pld_ready;
  logic [7:0]  pld_data;
  logic        pld_last;
  logic        err;
  logic [1:0]  err_code;
  logic        msg_end;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_msg_end = 0;
  int obs_msg_end = 0;
  int out_delay = 0;
  int ready_wait = 0;
  bit pld_toggle = 1'b0;

  logic [95:0] rec_q[$];
  logic [8:0]  pld_q[$];
  logic [1:0]  err_q[$];

  pb_field_decoder #(.MAX_VARINT_BYTES(10), .LEN_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_field_num(out_field_num),
    .out_wire_type(out_wire_type), .out_value(out_value),
    .pld_valid(pld_valid), .pld_ready(pld_ready), .pld_data(pld_data), .pld_last(pld_last),
    .err(err), .err_code(err_code), .msg_end(msg_end)
  );

  always #5 clk = ~clk;

  always begin
    @(negedge clk);
    if (out_valid) begin
      out_ready = (ready_wait >= out_delay);
      ready_wait++;
    end else begin
      out_ready  = 1'b0;
      ready_wait = 0;
    end
  end

  always begin
    @(negedge clk);
    if (pld_toggle) pld_ready = ~pld_ready;
    else pld_ready = 1'b1;
  end

  always begin
    logic [95:0] er;
    logic [8:0]  ep;
    logic [1:0]  ec;
    @(negedge clk);
    #2;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        n_checks++;
        if (rec_q.size() == 0) begin
          $display("FAIL record: got unexpected %h/%h/%h", out_field_num, out_wire_type, out_value);
        end else begin
          er = rec_q.pop_front();
          if ({out_field_num, out_wire_type, out_value} !== er)
            $display("FAIL record: got %h expected %h", {out_field_num, out_wire_type, out_value}, er);
          else n_pass++;
        end
      end
      if (pld_valid && pld_ready) begin
        n_checks++;
        if (pld_q.size() == 0) begin
          $display("FAIL payload: got unexpected %h last %b", pld_data, pld_last);
        end else begin
          ep = pld_q.pop_front();
          if ({pld_last, pld_data} !== ep)
            $display("FAIL payload: got %h expected %h", {pld_last, pld_data}, ep);
          else n_pass++;
        end
      end
      if (err) begin
        n_checks++;
        if (err_q.size() == 0) begin
          $display("FAIL err: got unexpected code %0d", err_code);
        end else begin
          ec = err_q.pop_front();
          if ({msg_end, err_code} !== {1'b0, ec})
            $display("FAIL err: got msg_end %b code %0d expected msg_end 0 code %0d", msg_end, err_code, ec);
          else n_pass++;
        end
      end
      if (msg_end) obs_msg_end++;
    end
  end

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    for (int t = 0; t < 200 && !done; t++) begin
      #1;
      done = in_ready;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!done) begin
      n_checks++;
      $display("FAIL send_timeout: byte %h not accepted within 200 cycles", d);
    end
  endtask

  task automatic check_drained(input string name);
    settle(20);
    n_checks++;
    if (rec_q.size() + pld_q.size() + err_q.size() != 0)
      $display("FAIL %s_pending: got rec %0d pld %0d err %0d outstanding expected 0",
               name, rec_q.size(), pld_q.size(), err_q.size());
    else n_pass++;
    n_checks++;
    if (obs_msg_end !== exp_msg_end)
      $display("FAIL %s_msg_end: got %0d expected %0d", name, obs_msg_end, exp_msg_end);
    else n_pass++;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({out_valid, pld_valid, err, msg_end} !== 4'b0000)
      $display("FAIL reset_ctrl: got %b expected 0000", {out_valid, pld_valid, err, msg_end});
    else n_pass++;
    n_checks++;
    if (err_code !== 2'd0) $display("FAIL reset_err_code: got %0d expected 0", err_code);
    else n_pass++;
    n_checks++;
    if ({out_field_num, out_wire_type, out_value} !== 96'd0)
      $display("FAIL reset_out: got %h expected 0", {out_field_num, out_wire_type, out_value});
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_varint();
    rec_q.push_back({29'd1, 3'd0, 64'd150});
    exp_msg_end++;
    send_byte(8'h08, 1'b0);
    send_byte(8'h96, 1'b0);
    send_byte(8'h01, 1'b1);
    check_drained("varint");
  endtask

  task automatic test_payload();
    logic [7:0] s [7];
    s = '{8'h74, 8'h65, 8'h73, 8'h74, 8'h69, 8'h6E, 8'h67};
    out_delay  = 3;
    pld_toggle = 1'b1;
    rec_q.push_back({29'd2, 3'd2, 64'd7});
    for (int i = 0; i < 7; i++) pld_q.push_back({(i == 6), s[i]});
    exp_msg_end++;
    send_byte(8'h12, 1'b0);
    send_byte(8'h07, 1'b0);
    for (int i = 0; i < 7; i++) send_byte(s[i], (i == 6));
    check_drained("payload");
    out_delay  = 0;
    pld_toggle = 1'b0;
  endtask

  task automatic test_fixed();
    rec_q.push_back({29'd1, 3'd5, 64'h0000_0000_0403_0201});
    rec_q.push_back({29'd2, 3'd1, 64'h0807_0605_0403_0201});
    exp_msg_end++;
    send_byte(8'h0D, 1'b0);
    for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b0);
    send_byte(8'h11, 1'b0);
    for (int i = 1; i <= 8; i++) send_byte(8'(i), (i == 8));
    check_drained("fixed");
  endtask

  task automatic test_bad_wire_type();
    err_q.push_back(2'd1);
    send_byte(8'h0B, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b1);
    rec_q.push_back({29'd1, 3'd0, 64'd1});
    exp_msg_end++;
    send_byte(8'h08, 1'b0);
    send_byte(8'h01, 1'b1);
    check_drained("bad_wt");
    n_checks++;
    if (err_code !== 2'd1) $display("FAIL bad_wt_code_hold: got %0d expected 1", err_code);
    else n_pass++;
  endtask

  task automatic test_overflow_trunc();
    err_q.push_back(2'd0);
    send_byte(8'h08, 1'b0);
    for (int i = 0; i < 10; i++) send_byte(8'hFF, 1'b0);
    send_byte(8'h01, 1'b1);
    check_drained("overflow");
    err_q.push_back(2'd2);
    send_byte(8'h08, 1'b0);
    send_byte(8'h96, 1'b1);
    check_drained("trunc");
    n_checks++;
    if (err_code !== 2'd2) $display("FAIL trunc_code: got %0d expected 2", err_code);
    else n_pass++;
    rec_q.push_back({29'd1, 3'd0, 64'd5});
    exp_msg_end++;
    send_byte(8'h08, 1'b0);
    send_byte(8'h05, 1'b1);
    check_drained("after_trunc");
  endtask

  task automatic test_field_zero();
    err_q.push_back(2'd3);
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b1);
    check_drained("fn0");
    n_checks++;
    if (err_code !== 2'd3) $display("FAIL fn0_code: got %0d expected 3", err_code);
    else n_pass++;
  endtask

  task automatic test_len_edges();
    rec_q.push_back({29'd3, 3'd2, 64'd0});
    exp_msg_end++;
    send_byte(8'h1A, 1'b0);
    send_byte(8'h00, 1'b1);
    check_drained("len0");
    rec_q.push_back({29'd1, 3'd2, 64'd3});
    pld_q.push_back({1'b0, 8'h41});
    pld_q.push_back({1'b1, 8'h42});
    err_q.push_back(2'd2);
    send_byte(8'h0A, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h41, 1'b0);
    send_byte(8'h42, 1'b1);
    check_drained("pld_trunc");
  endtask

  task automatic test_reset_mid_payload();
    rec_q.push_back({29'd1, 3'd2, 64'd5});
    pld_q.push_back({1'b0, 8'h61});
    pld_q.push_back({1'b0, 8'h62});
    send_byte(8'h0A, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h61, 1'b0);
    send_byte(8'h62, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h63;
    rst_n    = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, pld_valid, err, msg_end, err_code} !== 6'd0)
      $display("FAIL midreset_outs: got %b expected 000000", {out_valid, pld_valid, err, msg_end, err_code});
    else n_pass++;
    n_checks++;
    if ({out_field_num, out_wire_type, out_value} !== 96'd0)
      $display("FAIL midreset_rec: got %h expected 0", {out_field_num, out_wire_type, out_value});
    else n_pass++;
    in_valid = 1'b0;
    settle(2);
    rst_n = 1'b1;
    settle(1);
    rec_q.push_back({29'd1, 3'd0, 64'd1});
    exp_msg_end++;
    send_byte(8'h08, 1'b0);
    send_byte(8'h01, 1'b1);
    check_drained("after_reset");
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    out_ready = 1'b0;
    pld_ready = 1'b1;
    settle(3);
    test_reset();
    rst_n = 1'b1;
    settle(1);
    test_varint();
    test_payload();
    test_fixed();
    test_bad_wire_type();
    test_overflow_trunc();
    test_field_zero();
    test_len_edges();
    test_reset_mid_payload();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
